// File: rtl/pipe_ctrl_pkg.sv
// Shared decode/execute control types for the ID/EX boundary.
// ctrl_t bundle, opcode constants, halt FSM states, ctrl decode helper.
package pipe_ctrl_pkg;

  typedef struct packed {
    logic       alusrc;
    logic       memtoreg;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic [1:0] aluop;
    logic       branch;
    logic       halt;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } halt_state_e;

  localparam ctrl_t CTRL_BUBBLE = '0;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LW    = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_HALT  = 7'b1111111;

  function automatic ctrl_t ctrl_decode(
    input logic [6:0] opc
  );
    ctrl_t c;
    c = CTRL_BUBBLE;
    case (opc)
      OPC_R: begin
        c.regwrite = 1'b1;
        c.aluop    = 2'b10;
      end
      OPC_I: begin
        c.alusrc   = 1'b1;
        c.regwrite = 1'b1;
        c.aluop    = 2'b11;
      end
      OPC_LW: begin
        c.alusrc   = 1'b1;
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
        c.memread  = 1'b1;
      end
      OPC_STORE: begin
        c.alusrc   = 1'b1;
        c.memwrite = 1'b1;
      end
      OPC_BR: begin
        c.branch = 1'b1;
        c.aluop  = 2'b01;
      end
      OPC_HALT: c.halt = 1'b1;
      default: c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/halt_drain_fsm.sv
// Halt drain sequencer: RUN -> DRAIN (DRAIN_CYCLES edges) -> HALTED.
// Ports: clk, rst_n, i_halt_load in; o_force_bubble, o_halt_pending, o_halted out.
module halt_drain_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_halt_load,
  output logic o_force_bubble,
  output logic o_halt_pending,
  output logic o_halted
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DRAIN_CYCLES - 1);

  halt_state_e   r_state;
  halt_state_e   w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      RUN: begin
        if (i_halt_load) begin
          w_state_nxt = DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      DRAIN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = HALTED;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      HALTED: w_state_nxt = HALTED;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_force_bubble = (r_state != RUN);
  assign o_halt_pending = (r_state == DRAIN);
  assign o_halted       = (r_state == HALTED);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall hold, flush bubble and halt drain.
// In: clk, reset (async, low), stall, flush, id_*; out: ex_*, halt_pending,
// halted; bubble_cnt[15:0] only when ID_EX_BUBBLE_CNT_EN is defined.
module id_ex_pipe_reg
  import pipe_ctrl_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_rd1,
  input  logic [DATA_W-1:0]     id_rd2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [2:0]            id_funct3,
  input  logic [6:0]            id_funct7,
  input  ctrl_t                 id_ctrl,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_pc,
  output logic [DATA_W-1:0]     ex_rd1,
  output logic [DATA_W-1:0]     ex_rd2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [2:0]            ex_funct3,
  output logic [6:0]            ex_funct7,
  output ctrl_t                 ex_ctrl,
  output logic                  halt_pending,
  output logic                  halted
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [15:0]           bubble_cnt
`endif
);

  logic                  r_valid;
  logic [DATA_W-1:0]     r_pc;
  logic [DATA_W-1:0]     r_rd1;
  logic [DATA_W-1:0]     r_rd2;
  logic [DATA_W-1:0]     r_imm;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [2:0]            r_funct3;
  logic [6:0]            r_funct7;
  ctrl_t                 r_ctrl;

  logic w_force;
  logic w_hold;
  logic w_clear;
  logic w_halt_load;

  // Stall only holds when neither flush nor the drain
  // wants to push a bubble; bubbles beat the hold.
  assign w_hold  = stall & ~flush & ~w_force;
  assign w_clear = flush | w_force | ~id_valid;

  // HALT is accepted only on a real load in RUN.
  assign w_halt_load = id_valid & id_ctrl.halt &
                       ~flush & ~stall & ~w_force;

  halt_drain_fsm #(
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) u_fsm (
    .clk            (clk),
    .rst_n          (reset),
    .i_halt_load    (w_halt_load),
    .o_force_bubble (w_force),
    .o_halt_pending (halt_pending),
    .o_halted       (halted)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_funct3 <= '0;
      r_funct7 <= '0;
      r_ctrl   <= CTRL_BUBBLE;
    end else if (!w_hold) begin
      if (w_clear) begin
        r_valid  <= 1'b0;
        r_pc     <= '0;
        r_rd1    <= '0;
        r_rd2    <= '0;
        r_imm    <= '0;
        r_rs1    <= '0;
        r_rs2    <= '0;
        r_rd     <= '0;
        r_funct3 <= '0;
        r_funct7 <= '0;
        r_ctrl   <= CTRL_BUBBLE;
      end else begin
        r_valid  <= 1'b1;
        r_pc     <= id_pc;
        r_rd1    <= id_rd1;
        r_rd2    <= id_rd2;
        r_imm    <= id_imm;
        r_rs1    <= id_rs1;
        r_rs2    <= id_rs2;
        r_rd     <= id_rd;
        r_funct3 <= id_funct3;
        r_funct7 <= id_funct7;
        r_ctrl   <= id_ctrl;
      end
    end
  end

  assign ex_valid  = r_valid;
  assign ex_pc     = r_pc;
  assign ex_rd1    = r_rd1;
  assign ex_rd2    = r_rd2;
  assign ex_imm    = r_imm;
  assign ex_rs1    = r_rs1;
  assign ex_rs2    = r_rs2;
  assign ex_rd     = r_rd;
  assign ex_funct3 = r_funct3;
  assign ex_funct7 = r_funct7;
  assign ex_ctrl   = r_ctrl;

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [15:0] r_bubble_cnt;
  logic        w_cnt_evt;

  // Bubbles injected by the drain/halt are not counted.
  assign w_cnt_evt = ~w_force &
                     (flush | (~stall & ~id_valid));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bubble_cnt <= '0;
    end else if (w_cnt_evt &&
                 r_bubble_cnt != 16'hFFFF) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
